// File: rtl/switch_pkg.sv
// Shared types and default dimensions for the switch egress path.
package switch_pkg;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_OUTPUT_QTY = 8;

    typedef logic [DEF_DATA_WIDTH-1:0] beat_t;
    typedef logic [15:0]               drop_cnt_t;

    localparam drop_cnt_t DROP_CNT_MAX = 16'hFFFF;

    function automatic drop_cnt_t sat_inc(input drop_cnt_t cnt);
        return (cnt == DROP_CNT_MAX) ? cnt : cnt + 16'd1;
    endfunction
endpackage

// File: rtl/egress_fifo.sv
// One egress queue: first-word fall-through FIFO with registered flags and a saturating drop counter.
// Push-to-head latency 1 cycle; the producer cannot be stalled, so beats arriving while full are counted and discarded.
module egress_fifo
    import switch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_vld,
    input  logic [DATA_WIDTH-1:0] push_dat,
    output logic                  pop_vld,
    output logic [DATA_WIDTH-1:0] pop_dat,
    input  logic                  pop_rdy,
    output logic                  almost_full,
    output logic                  full,
    output drop_cnt_t             drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_valid;
    logic                  r_full;
    logic                  r_af;
    logic [DATA_WIDTH-1:0] r_head;
    drop_cnt_t             r_drop_cnt;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [PTR_W-1:0]      w_rd_ptr_inc;
    logic [LVL_W-1:0]      w_level_nxt;
    logic [DATA_WIDTH-1:0] w_head_nxt;

    assign w_pop        = r_valid & pop_rdy;
    assign w_push       = push_vld & (~r_full | w_pop);
    assign w_drop       = push_vld & r_full & ~w_pop;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // The head is a register; a beat that becomes the head this edge is taken straight from the input.
    always_comb begin
        w_head_nxt = r_head;
        if (w_push && (r_level == '0 || (w_pop && r_level == LVL_ONE))) begin
            w_head_nxt = push_dat;
        end else if (w_pop && r_level > LVL_ONE) begin
            w_head_nxt = r_mem[w_rd_ptr_inc];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
            r_af       <= 1'b0;
            r_head     <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
            r_full  <= (w_level_nxt == LVL_FULL);
            r_af    <= (w_level_nxt >= LVL_AF);
            r_head  <= w_head_nxt;
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign pop_vld     = r_valid;
    assign pop_dat     = r_head;
    assign almost_full = r_af;
    assign full        = r_full;
    assign drop_count  = r_drop_cnt;
endmodule

// File: rtl/switch_egress_queue.sv
// Per-output-port egress queues behind the switch; queues are fully independent.
// Push-to-output latency 1 cycle; no backpressure toward the switch, overflow beats are dropped and counted per port.
module switch_egress_queue
    import switch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUTPUT_QTY = DEF_OUTPUT_QTY,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [OUTPUT_QTY-1:0]                 sw_valid,
    input  logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0] sw_data,
    output logic [OUTPUT_QTY-1:0]                 out_valid,
    output logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0] out_data,
    input  logic [OUTPUT_QTY-1:0]                 out_ready,
    output logic [OUTPUT_QTY-1:0]                 almost_full,
    output logic [OUTPUT_QTY-1:0]                 full,
    output drop_cnt_t [OUTPUT_QTY-1:0]            drop_count
);
    for (genvar g = 0; g < OUTPUT_QTY; g++) begin : g_queue
        egress_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .AF_MARGIN  (AF_MARGIN)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push_vld    (sw_valid[g]),
            .push_dat    (sw_data[g]),
            .pop_vld     (out_valid[g]),
            .pop_dat     (out_data[g]),
            .pop_rdy     (out_ready[g]),
            .almost_full (almost_full[g]),
            .full        (full[g]),
            .drop_count  (drop_count[g])
        );
    end
endmodule

// File: tb/tb_switch_egress_queue.sv
// Directed and scoreboard checks of switch_egress_queue with 4-deep queues and an almost-full margin of 1.
module tb_switch_egress_queue;
    import switch_pkg::*;

    localparam int NQ    = 8;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NQ-1:0]        sw_valid;
    logic [NQ-1:0][63:0]  sw_data;
    logic [NQ-1:0]        out_valid;
    logic [NQ-1:0][63:0]  out_data;
    logic [NQ-1:0]        out_ready;
    logic [NQ-1:0]        almost_full;
    logic [NQ-1:0]        full;
    drop_cnt_t [NQ-1:0]   drop_count;

    int        n_checks = 0;
    int        n_fail   = 0;
    drop_cnt_t exp_drop [NQ];
    beat_t     q [NQ][$];

    switch_egress_queue #(
        .DATA_WIDTH (64),
        .OUTPUT_QTY (NQ),
        .FIFO_DEPTH (DEPTH),
        .AF_MARGIN  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_valid    (sw_valid),
        .sw_data     (sw_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .almost_full (almost_full),
        .full        (full),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; sw_valid = '0; out_ready = '0; sw_data = '0;
        for (int p = 0; p < NQ; p++) exp_drop[p] = '0;
        repeat (2) tick();
        n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL reset_out_valid: got %h want 00", out_valid); end
        n_checks++; if (full !== '0) begin n_fail++; $display("FAIL reset_full: got %h want 00", full); end
        n_checks++; if (almost_full !== '0) begin n_fail++; $display("FAIL reset_almost_full: got %h want 00", almost_full); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++; if (drop_count !== '0) begin n_fail++; $display("FAIL reset_drop_count: got %h want 0", drop_count); end
        reset = 1'b0;
        tick();
        n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL reset_release_valid: got %h want 00", out_valid); end
    endtask

    task automatic test_single_beat();
        sw_valid = 8'h08; sw_data[3] = 64'hA5; out_ready = 8'h08;
        tick();
        sw_valid = '0;
        n_checks++; if (out_valid !== 8'h08) begin n_fail++; $display("FAIL single_valid: got %h want 08", out_valid); end
        n_checks++; if (out_data[3] !== 64'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", out_data[3]); end
        tick();
        n_checks++; if (out_valid !== 8'h00) begin n_fail++; $display("FAIL single_one_cycle: got %h want 00", out_valid); end
        n_checks++; if (out_data[3] !== 64'hA5) begin n_fail++; $display("FAIL single_hold_data: got %h want a5", out_data[3]); end
        tick();
        n_checks++; if (out_valid !== 8'h00) begin n_fail++; $display("FAIL single_idle: got %h want 00", out_valid); end
        out_ready = '0; sw_data = '0;
    endtask

    task automatic test_fill_drop();
        int lvl;
        out_ready = '0;
        for (int b = 1; b <= 6; b++) begin
            sw_valid = 8'h01; sw_data[0] = 64'(b);
            tick();
            lvl = (b > DEPTH) ? DEPTH : b;
            n_checks++; if (almost_full[0] !== (lvl >= DEPTH - 1)) begin n_fail++; $display("FAIL fill_af beat %0d: got %b want %b", b, almost_full[0], lvl >= DEPTH - 1); end
            n_checks++; if (full[0] !== (lvl == DEPTH)) begin n_fail++; $display("FAIL fill_full beat %0d: got %b want %b", b, full[0], lvl == DEPTH); end
            n_checks++; if (out_data[0] !== 64'h1) begin n_fail++; $display("FAIL fill_head beat %0d: got %h want 1", b, out_data[0]); end
        end
        sw_valid = '0;
        exp_drop[0] = 16'd2;
        n_checks++; if (drop_count[0] !== 16'd2) begin n_fail++; $display("FAIL fill_drop_count: got %0d want 2", drop_count[0]); end
        out_ready = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== 64'(k)) begin n_fail++; $display("FAIL fill_drain %0d: got v=%b d=%h want v=1 d=%h", k, out_valid[0], out_data[0], 64'(k)); end
            tick();
        end
        n_checks++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL fill_drained: got %b want 0", out_valid[0]); end
        out_ready = '0;
    endtask

    task automatic test_full_push_pop();
        logic [63:0] exp_order [4];
        exp_order[0] = 64'd2; exp_order[1] = 64'd3; exp_order[2] = 64'd4; exp_order[3] = 64'd9;
        out_ready = '0;
        for (int b = 1; b <= 4; b++) begin
            sw_valid = 8'h01; sw_data[0] = 64'(b);
            tick();
        end
        sw_valid = 8'h01; sw_data[0] = 64'd9; out_ready = 8'h01;
        tick();
        sw_valid = '0;
        n_checks++; if (full[0] !== 1'b1) begin n_fail++; $display("FAIL pp_full: got %b want 1", full[0]); end
        n_checks++; if (drop_count[0] !== exp_drop[0]) begin n_fail++; $display("FAIL pp_drop: got %0d want %0d", drop_count[0], exp_drop[0]); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== exp_order[k]) begin n_fail++; $display("FAIL pp_drain %0d: got v=%b d=%h want v=1 d=%h", k, out_valid[0], out_data[0], exp_order[k]); end
            tick();
        end
        n_checks++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL pp_drained: got %b want 0", out_valid[0]); end
        out_ready = '0;
    endtask

    task automatic test_streaming();
        out_ready = '1;
        for (int c = 0; c < 100; c++) begin
            sw_valid = '1;
            for (int p = 0; p < NQ; p++) sw_data[p] = (64'(p) << 32) | 64'(c);
            tick();
            n_checks++; if (out_valid !== '1) begin n_fail++; $display("FAIL stream_valid c=%0d: got %h want ff", c, out_valid); end
            n_checks++; if (full !== '0 || almost_full !== '0) begin n_fail++; $display("FAIL stream_level c=%0d: got full=%h af=%h want 00", c, full, almost_full); end
            for (int p = 0; p < NQ; p++) begin
                n_checks++; if (out_data[p] !== ((64'(p) << 32) | 64'(c))) begin n_fail++; $display("FAIL stream_data c=%0d p=%0d: got %h", c, p, out_data[p]); end
            end
        end
        sw_valid = '0;
        tick();
        n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL stream_end: got %h want 00", out_valid); end
        for (int p = 0; p < NQ; p++) begin
            n_checks++; if (drop_count[p] !== exp_drop[p]) begin n_fail++; $display("FAIL stream_drop p=%0d: got %0d want %0d", p, drop_count[p], exp_drop[p]); end
        end
        out_ready = '0;
    endtask

    task automatic test_random();
        logic was_full, pop;
        for (int p = 0; p < NQ; p++) q[p].delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int p = 0; p < NQ; p++) begin
                n_checks++; if (out_valid[p] !== (q[p].size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d p=%0d: got %b want %b", cyc, p, out_valid[p], q[p].size() != 0); end
                if (q[p].size() != 0) begin
                    n_checks++; if (out_data[p] !== q[p][0]) begin n_fail++; $display("FAIL rnd_data cyc=%0d p=%0d: got %h want %h", cyc, p, out_data[p], q[p][0]); end
                end
                n_checks++; if (full[p] !== (q[p].size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full cyc=%0d p=%0d: got %b", cyc, p, full[p]); end
                n_checks++; if (almost_full[p] !== (q[p].size() >= DEPTH - 1)) begin n_fail++; $display("FAIL rnd_af cyc=%0d p=%0d: got %b", cyc, p, almost_full[p]); end
            end
            sw_valid  = NQ'($urandom);
            out_ready = NQ'($urandom);
            for (int p = 0; p < NQ; p++) begin
                sw_data[p] = {$urandom, $urandom};
                was_full = (q[p].size() == DEPTH);
                pop = (q[p].size() != 0) && out_ready[p];
                if (pop) void'(q[p].pop_front());
                if (sw_valid[p]) begin
                    if (!was_full || pop) q[p].push_back(sw_data[p]);
                    else if (exp_drop[p] != 16'hFFFF) exp_drop[p] = exp_drop[p] + 16'd1;
                end
            end
            tick();
        end
        sw_valid = '0; out_ready = '0;
        for (int p = 0; p < NQ; p++) begin
            n_checks++; if (drop_count[p] !== exp_drop[p]) begin n_fail++; $display("FAIL rnd_drop p=%0d: got %0d want %0d", p, drop_count[p], exp_drop[p]); end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        out_ready = '0;
        for (int i = 0; i < 9; i++) begin
            sw_valid = (i < 2) ? 8'hFF : 8'h04;
            for (int p = 0; p < NQ; p++) sw_data[p] = 64'(i + 1);
            tick();
        end
        sw_valid = '0;
        n_checks++; if (drop_count[2] !== 16'd5) begin n_fail++; $display("FAIL rm_pre_drop: got %0d want 5", drop_count[2]); end
        n_checks++; if (out_valid !== 8'hFF || full !== 8'h04) begin n_fail++; $display("FAIL rm_pre_state: got v=%h f=%h want v=ff f=04", out_valid, full); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL rm_valid: got %h want 00", out_valid); end
        n_checks++; if (full !== '0 || almost_full !== '0) begin n_fail++; $display("FAIL rm_flags: got f=%h af=%h want 00", full, almost_full); end
        n_checks++; if (drop_count !== '0) begin n_fail++; $display("FAIL rm_drop: got %h want 0", drop_count); end
        @(posedge clk); #3;
        reset = 1'b0;
        tick();
        sw_data = '0; sw_data[2] = 64'h1; sw_valid = 8'h04;
        tick();
        sw_valid = '0;
        n_checks++; if (out_valid !== 8'h04 || out_data[2] !== 64'h1) begin n_fail++; $display("FAIL rm_first_beat: got v=%h d=%h want v=04 d=1", out_valid, out_data[2]); end
    endtask

    task automatic test_saturation();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        out_ready = '0; sw_valid = '1;
        for (int i = 0; i < DEPTH + 65534; i++) begin
            for (int p = 0; p < NQ; p++) sw_data[p] = 64'(i);
            tick();
        end
        for (int p = 0; p < NQ; p++) begin
            n_checks++; if (drop_count[p] !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre p=%0d: got %h want fffe", p, drop_count[p]); end
        end
        tick();
        n_checks++; if (drop_count[0] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", drop_count[0]); end
        repeat (3) tick();
        sw_valid = '0;
        for (int p = 0; p < NQ; p++) begin
            n_checks++; if (drop_count[p] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold p=%0d: got %h want ffff", p, drop_count[p]); end
        end
        out_ready = '1;
        for (int k = 0; k < DEPTH; k++) begin
            n_checks++; if (out_valid[5] !== 1'b1 || out_data[5] !== 64'(k)) begin n_fail++; $display("FAIL sat_contents %0d: got v=%b d=%h want v=1 d=%h", k, out_valid[5], out_data[5], 64'(k)); end
            tick();
        end
        n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL sat_drained: got %h want 00", out_valid); end
        out_ready = '0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_fill_drop();
        test_full_push_pop();
        test_streaming();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
